// File: rtl/sub_32bit_pipe_pkg.sv
// Shared widths and pipeline stage record types for the 32-bit pipelined subtractor.
package sub_pkg;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned FULL_W = 32;

    // Stage 1: low-half difference, carry into the high half, and the high-half operands.
    typedef struct packed {
        logic [HALF_W-1:0] lo_sum;
        logic              c16;
        logic [HALF_W-1:0] hiA;
        logic [HALF_W-1:0] hiNB;
    } s1_t;

    // Stage 2: full difference and borrow out.
    typedef struct packed {
        logic [FULL_W-1:0] diff;
        logic              borrow;
    } s2_t;

endpackage

// File: rtl/sub_32bit_pipe_cla.sv
// 16-bit carry-lookahead adder computing a + nb + cin.
// It is built from four 4-bit groups with group generate/propagate and lookahead between groups.
module cla_sub_16
    import sub_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] nb,
    input  logic              cin,
    output logic [HALF_W-1:0] s,
    output logic              cout
);

    logic [HALF_W-1:0] p;
    logic [HALF_W-1:0] g;
    logic [3:0]        grp_g;
    logic [3:0]        grp_p;
    logic [4:0]        grp_c;
    logic [HALF_W:0]   c;

    // Bit propagate/generate, group terms, inter-group lookahead, then in-group carries.
    always_comb begin
        p     = a ^ nb;
        g     = a & nb;
        grp_g = '0;
        grp_p = '1;
        grp_c = '0;
        c     = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                grp_g[k] = g[4*k+j] | (p[4*k+j] & grp_g[k]);
                grp_p[k] = grp_p[k] & p[4*k+j];
            end
        end
        grp_c[0] = cin;
        for (int unsigned k = 0; k < 4; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k] = grp_c[k];
            for (int unsigned j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[HALF_W] = grp_c[4];
        s    = p ^ c[HALF_W-1:0];
        cout = grp_c[4];
    end

endmodule

// File: rtl/sub_32bit_pipe.sv
// Two-stage pipelined 32-bit subtractor D = A - B with borrow out and valid/ready flow control.
// Optional feature macro: SUB_32BIT_PIPE_OVF_EN adds the registered signed-overflow output OVF.
module sub_32bit_pipe
    import sub_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FULL_W-1:0] A,
    input  logic [FULL_W-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FULL_W-1:0] D,
`ifdef SUB_32BIT_PIPE_OVF_EN
    output logic              OVF,
`endif
    output logic              B32
);

    s1_t               s1_q;
    s2_t               s2_q;
    logic              s1_valid;
    logic              s2_valid;
    logic              s1_adv;
    logic              s2_adv;
    logic [HALF_W-1:0] lo_nb;
    logic [HALF_W-1:0] lo_sum;
    logic              lo_cout;
    logic [HALF_W-1:0] hi_sum;
    logic              hi_cout;

    assign lo_nb = ~B[HALF_W-1:0];

    cla_sub_16 u_lo (
        .a    (A[HALF_W-1:0]),
        .nb   (lo_nb),
        .cin  (1'b1),
        .s    (lo_sum),
        .cout (lo_cout)
    );

    cla_sub_16 u_hi (
        .a    (s1_q.hiA),
        .nb   (s1_q.hiNB),
        .cin  (s1_q.c16),
        .s    (hi_sum),
        .cout (hi_cout)
    );

    // Handshake: a stage advances when it is empty or its successor advances.
    always_comb begin
        s2_adv   = ~s2_valid | out_ready;
        s1_adv   = ~s1_valid | s2_adv;
        in_ready = s1_adv;
    end

    // Stage 1: low-half subtraction and high-half operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (s1_adv && in_valid) begin
                s1_q.lo_sum <= lo_sum;
                s1_q.c16    <= lo_cout;
                s1_q.hiA    <= A[FULL_W-1:HALF_W];
                s1_q.hiNB   <= ~B[FULL_W-1:HALF_W];
            end
        end
    end

    // Stage 2: high-half subtraction; bubbles never overwrite a held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else begin
            if (s2_adv) s2_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                s2_q.diff   <= {hi_sum, s1_q.lo_sum};
                s2_q.borrow <= ~hi_cout;
            end
        end
    end

`ifdef SUB_32BIT_PIPE_OVF_EN
    logic s1_sx;
    logic ovf_q;

    // Overflow path: operand sign difference travels with stage 1, overflow registers with D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sx <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (s1_adv && in_valid) s1_sx <= A[FULL_W-1] ^ B[FULL_W-1];
            if (s2_adv && s1_valid) ovf_q <= s1_sx & (s1_q.hiA[HALF_W-1] ^ hi_sum[HALF_W-1]);
        end
    end

    assign OVF = ovf_q;
`endif

    assign out_valid = s2_valid;
    assign D         = s2_q.diff;
    assign B32       = s2_q.borrow;

endmodule

// File: tb/tb_sub_32bit_pipe.sv
// Self-checking bench for sub_32bit_pipe: table-driven stream plus back-pressure and reset sequences.
module tb_sub_32bit_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        B32;
    logic        ovf;

    int unsigned checks;
    int unsigned failures;

    sub_32bit_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
`ifdef SUB_32BIT_PIPE_OVF_EN
        .OVF       (ovf),
`endif
        .B32       (B32)
    );

`ifndef SUB_32BIT_PIPE_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        b32;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string name, input vec_t v);
        check({name, " valid"}, {31'd0, out_valid}, 32'd1);
        check({name, " D"}, D, v.d);
        check({name, " B32"}, {31'd0, B32}, {31'd0, v.b32});
`ifdef SUB_32BIT_PIPE_OVF_EN
        check({name, " OVF"}, {31'd0, ovf}, {31'd0, v.ovf});
`endif
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    vec_t x;
    vec_t y;
    vec_t z;

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0};
        vecs[1]  = '{32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[2]  = '{32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b0};
        vecs[3]  = '{32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0};
        vecs[4]  = '{32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b0};
        vecs[5]  = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[8]  = '{32'hDEADBEEF, 32'h12345678, 32'hCC796877, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000FFFF, 32'h00010000, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[10] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1};

        // Reset state while rst_n is held low.
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        #12;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset D", D, 32'd0);
        check("reset B32", {31'd0, B32}, 32'd0);
        check("reset OVF", {31'd0, ovf}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post-reset in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back stream with out_ready high: one result per cycle, latency 2.
        for (int i = 0; i <= 11; i++) begin
            if (i < 11) begin
                in_valid = 1'b1;
                A        = vecs[i].a;
                B        = vecs[i].b;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check($sformatf("stream in_ready %0d", i), {31'd0, in_ready}, 32'd1);
            tick();
            if (i == 0) check("stream first-cycle valid", {31'd0, out_valid}, 32'd0);
            else        check_result($sformatf("stream %0d", i - 1), vecs[i - 1]);
        end
        in_valid = 1'b0;
        tick();
        check("stream drained", {31'd0, out_valid}, 32'd0);

        // Back-pressure: third op is refused until the output drains.
        x = vecs[0];
        y = vecs[1];
        z = vecs[8];
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = x.a; B = x.b;
        tick();
        A = y.a; B = y.b;
        #1;
        check("bp in_ready 2nd", {31'd0, in_ready}, 32'd1);
        tick();
        A = z.a; B = z.b;
        #1;
        check("bp in_ready full", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_result($sformatf("bp hold %0d", i), x);
            check($sformatf("bp in_ready hold %0d", i), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp in_ready release", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_result("bp out 2", y);
        tick();
        check_result("bp out 3", z);
        tick();
        check("bp no duplicate", {31'd0, out_valid}, 32'd0);

        // Reset mid-flight with two ops held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = vecs[3].a; B = vecs[3].b;
        tick();
        A = vecs[5].a; B = vecs[5].b;
        tick();
        in_valid = 1'b0;
        check_result("mid held", vecs[3]);
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        check("mid reset D", D, 32'd0);
        check("mid reset B32", {31'd0, B32}, 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("no stale %0d", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("post mid in_ready %0d", i), {31'd0, in_ready}, 32'd1);
        end

        // Pipeline still works after mid-flight reset.
        in_valid = 1'b1;
        A = vecs[2].a; B = vecs[2].b;
        tick();
        in_valid = 1'b0;
        tick();
        check_result("after reset op", vecs[2]);

        do_reset();
        check("final idle", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
